// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM state encoding and baud math.
package uart_tx_cfg_pkg;

    // Parity mode selectors
    localparam int unsigned ParNone = 0;
    localparam int unsigned ParOdd  = 1;
    localparam int unsigned ParEven = 2;

    // Line FSM states, 3-bit encoding shared with the receiver
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // System clocks per serial bit (integer divide)
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period divider: tick pulses for one clock at the end of each bit period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: wrap at end of period, or restart from zero on request
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with valid/ready input and gap-free back-to-back framing.
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 o_bit,
    output logic                 busy
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned IdxW       = $clog2(DATA_BITS + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY > 2) ||
        ((STOP_BITS != 1) && (STOP_BITS != 2)) || (ClksPerBit < 2)) begin : g_param_err
        $error("uart_tx_cfg: illegal parameter combination");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 o_bit_q, o_bit_d;
    logic                 bit_end, accept, last_stop, restart;

    assign last_stop = (stop_q == 1'(STOP_BITS - 1));
    // Any state change (including stop->start) realigns the bit period
    assign restart   = accept || (state_d != state_q);

    uart_baud_tick #(
        .CLKS_PER_BIT(ClksPerBit)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (bit_end)
    );

    // Next-state, handshake and datapath updates
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        par_d    = par_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        tx_ready = 1'b0;
        unique case (state_q)
            StIdle: tx_ready = 1'b1;
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxLast) begin
                        state_d = (PARITY == ParNone) ? StStop : StParity;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    stop_d  = 1'b0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (last_stop) begin
                        // Last clock of the frame: open the window for a gap-free next word
                        tx_ready = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            tx_ready = 1'b0;
        end
        accept = tx_valid && tx_ready;
        if (accept) begin
            state_d = StStart;
            shift_d = tx_data;
            par_d   = (PARITY == ParOdd) ? ~(^tx_data) : ^tx_data;
        end
    end

    // Line level for the current state; registered one cycle behind the FSM
    always_comb begin
        o_bit_d = 1'b1;
        unique case (state_q)
            StIdle:   o_bit_d = 1'b1;
            StStart:  o_bit_d = 1'b0;
            StData:   o_bit_d = shift_q[0];
            StParity: o_bit_d = par_q;
            StStop:   o_bit_d = 1'b1;
            default:  o_bit_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            o_bit_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            o_bit_q <= o_bit_d;
        end
    end

    assign o_bit = o_bit_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four frame formats at 8 clocks per bit.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] v, rdy, ob, bsy;
    logic [7:0] d8;
    logic [6:0] d7;
    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] tartz [5] = '{8'h54, 8'h61, 8'h72, 8'h74, 8'h7A};

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
    uart_tx_cfg #(.CLK_FREQ(8000), .BAUD(1000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst(rst), .tx_valid(v[0]), .tx_data(d8), .tx_ready(rdy[0]),
           .o_bit(ob[0]), .busy(bsy[0]));
    uart_tx_cfg #(.CLK_FREQ(8000), .BAUD(1000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst(rst), .tx_valid(v[1]), .tx_data(d8), .tx_ready(rdy[1]),
           .o_bit(ob[1]), .busy(bsy[1]));
    uart_tx_cfg #(.CLK_FREQ(8000), .BAUD(1000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst(rst), .tx_valid(v[2]), .tx_data(d8), .tx_ready(rdy[2]),
           .o_bit(ob[2]), .busy(bsy[2]));
    uart_tx_cfg #(.CLK_FREQ(8000), .BAUD(1000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u_7n2 (.clk(clk), .rst(rst), .tx_valid(v[3]), .tx_data(d7), .tx_ready(rdy[3]),
           .o_bit(ob[3]), .busy(bsy[3]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slot i of the returned vector is the i-th line bit; unused slots are stop/idle ones
    function automatic logic [15:0] mk_frame(input logic [7:0] data, input int dbits,
                                             input bit par_en, input logic par_bit);
        logic [15:0] fr;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < dbits; i++) fr[1+i] = data[i];
        if (par_en) fr[1+dbits] = par_bit;
        return fr;
    endfunction

    task automatic drive(input int sel, input bit val, input logic [7:0] data);
        v[sel] = val;
        if (sel == 3) d7 = data[6:0];
        else d8 = data;
    endtask

    task automatic chk_idle(input int sel);
        chk("idle_rdy", rdy[sel], 1'b1);
        chk("idle_busy", bsy[sel], 1'b0);
        chk("idle_line", ob[sel], 1'b1);
    endtask

    // Handshake from idle; valid is left high and must be held off during the frame
    task automatic start(input int sel, input logic [7:0] data);
        drive(sel, 1'b1, data);
        step();
        chk("acc_busy", bsy[sel], 1'b1);
        chk("acc_rdy", rdy[sel], 1'b0);
        chk("acc_line", ob[sel], 1'b1);
    endtask

    // Check line/busy/ready each clock after the accept edge; at the ready clock drive nv/nd
    task automatic expect_frame(input int sel, input logic [15:0] fr, input int len,
                                input bit nv, input logic [7:0] nd, input bit poke);
        int nclk;
        nclk = len * 8;
        for (int k = 1; k <= nclk; k++) begin
            step();
            chk("line", ob[sel], fr[(k-1)/8]);
            if (k < nclk) chk("busy", bsy[sel], 1'b1);
            else chk("busy_end", bsy[sel], nv);
            if (k == nclk - 2) chk("rdy_early", rdy[sel], 1'b0);
            if (k == nclk - 1) begin
                chk("rdy_last", rdy[sel], 1'b1);
                drive(sel, nv, nd);
            end
            if (poke && k == nclk / 2) begin
                chk("rdy_mid", rdy[sel], 1'b0);
                drive(sel, 1'b1, 8'hFF);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        v   = '0;
        d8  = '0;
        d7  = '0;
        step();
        step();
        for (int i = 0; i < 4; i++) chk("rst_rdy", rdy[i], 1'b0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) chk_idle(i);

        // 8N1 single 'T'
        start(0, 8'h54);
        expect_frame(0, mk_frame(8'h54, 8, 1'b0, 1'b0), 10, 1'b0, 8'h00, 1'b0);
        chk_idle(0);

        // Stream "Tartz" with valid held high
        start(0, tartz[0]);
        for (int i = 0; i < 5; i++) begin
            expect_frame(0, mk_frame(tartz[i], 8, 1'b0, 1'b0), 10, (i < 4),
                         (i < 4) ? tartz[(i < 4) ? i + 1 : 0] : 8'h00, 1'b0);
        end
        chk_idle(0);

        // Even parity, 0x07 -> parity 1
        start(1, 8'h07);
        expect_frame(1, mk_frame(8'h07, 8, 1'b1, 1'b1), 11, 1'b0, 8'h00, 1'b0);
        chk_idle(1);

        // Odd parity, 0x07 -> parity 0
        start(2, 8'h07);
        expect_frame(2, mk_frame(8'h07, 8, 1'b1, 1'b0), 11, 1'b0, 8'h00, 1'b0);
        chk_idle(2);

        // 7 data bits, 2 stop bits
        start(3, 8'h41);
        expect_frame(3, mk_frame(8'h41, 7, 1'b0, 1'b0), 10, 1'b0, 8'h00, 1'b0);
        chk_idle(3);

        // Reset at clk 30 of an all-zero frame
        start(0, 8'h00);
        for (int k = 1; k <= 29; k++) begin
            step();
            chk("pre_rst_line", ob[0], 1'b0);
        end
        rst = 1'b1;
        drive(0, 1'b1, 8'hFF);
        chk("rst_mid_rdy", rdy[0], 1'b0);
        step();
        chk("rst_line", ob[0], 1'b1);
        chk("rst_busy", bsy[0], 1'b0);
        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("post_rst_line", ob[0], 1'b1);
            chk("post_rst_busy", bsy[0], 1'b0);
        end
        start(0, 8'hA5);
        expect_frame(0, mk_frame(8'hA5, 8, 1'b0, 1'b0), 10, 1'b0, 8'h00, 1'b0);
        chk_idle(0);

        // Data/valid changes mid-frame; next word only at the ready clock
        start(0, 8'h54);
        expect_frame(0, mk_frame(8'h54, 8, 1'b0, 1'b0), 10, 1'b1, 8'h3C, 1'b1);
        expect_frame(0, mk_frame(8'h3C, 8, 1'b0, 1'b0), 10, 1'b0, 8'h00, 1'b0);
        chk_idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
